// File: rtl/pwm_multi_breathe.sv
// pwm_multi_breathe: CHANNELS PWM outputs sharing one free-running period counter,
// with double-buffered duties. Define BREATHE_EN to build the per-channel breathe ramp.
module pwm_multi_breathe #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 3,
  parameter int STEP     = 1,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_duty,
  input  logic                wr_mode,
  output logic                period_end,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt;
  logic             boundary;
  logic             write_en;

  // Writes are refused on the boundary cycle so a shadow load never races the transfer.
  assign boundary = (cnt == CNT_MAX);
  assign wr_ready = ~boundary;
  assign write_en = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      period_end <= boundary;
    end
  end

`ifdef BREATHE_EN
  localparam logic [WIDTH:0]   MAX_EXT  = {1'b0, CNT_MAX};
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_LO  = STEP_EXT[WIDTH-1:0];
`else
  logic unused_mode;
  assign unused_mode = wr_mode;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] shadow_duty;
    logic             pending;
    logic             sel;
    logic             pwm_q;
`ifdef BREATHE_EN
    logic             mode;
    logic             shadow_mode;
    logic             dir_down;
    logic [WIDTH:0]   duty_ext;
    logic [WIDTH:0]   up_sum;

    assign duty_ext = {1'b0, duty};
    assign up_sum   = duty_ext + STEP_EXT;
`endif

    // Out-of-range channel indices match no slot, so such writes vanish silently.
    assign sel = write_en && (wr_chan == CW'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        duty        <= '0;
        shadow_duty <= '0;
        pending     <= 1'b0;
        pwm_q       <= 1'b0;
`ifdef BREATHE_EN
        mode        <= 1'b0;
        shadow_mode <= 1'b0;
        dir_down    <= 1'b0;
`endif
      end else begin
        pwm_q <= (cnt < duty);
        if (sel) begin
          shadow_duty <= wr_duty;
          pending     <= 1'b1;
`ifdef BREATHE_EN
          shadow_mode <= wr_mode;
`endif
        end
        if (boundary) begin
          if (pending) begin
            duty    <= shadow_duty;
            pending <= 1'b0;
`ifdef BREATHE_EN
            mode     <= shadow_mode;
            dir_down <= 1'b0;
          end else if (mode) begin
            // Ramp saturates at both ends and reverses direction there.
            if (!dir_down) begin
              if (up_sum >= MAX_EXT) begin
                duty     <= CNT_MAX;
                dir_down <= 1'b1;
              end else begin
                duty <= up_sum[WIDTH-1:0];
              end
            end else begin
              if (duty_ext <= STEP_EXT) begin
                duty     <= '0;
                dir_down <= 1'b0;
              end else begin
                duty <= duty - STEP_LO;
              end
            end
`endif
          end
        end
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule
